// File: rtl/wf_pending_tracker_pkg.sv
// Shared constants and helpers for the per-wavefront pending-op tracker.
package wf_pending_tracker_pkg;

    localparam int PEND_CNT_W = 3;
    localparam logic [PEND_CNT_W-1:0] PEND_CNT_MAX = 3'd7;

    // True when a wavefront id addresses a real slot; out-of-range ids are ignored.
    function automatic logic wfid_in_range(input int unsigned wfid, input int unsigned num_wf);
        return wfid < num_wf;
    endfunction

endpackage

// File: rtl/pending_count_slot.sv
// One wavefront slot: a saturating 3-bit pending count with clear/inc/dec
// next-state logic, full/zero decode and per-slot error hits.
module pending_count_slot
    import wf_pending_tracker_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic                  dec,
    output logic [PEND_CNT_W-1:0] count,
    output logic                  full,
    output logic                  zero,
    output logic                  ovf_hit,
    output logic                  unf_hit
);

    logic [PEND_CNT_W-1:0] base;
    logic [PEND_CNT_W-1:0] count_next;
    logic                  dec_eff;

    // Next count: clear forces the base to 0 and swallows a same-cycle retire;
    // inc and dec together cancel; saturation at either end flags an error hit.
    always_comb begin
        count_next = count;
        ovf_hit    = 1'b0;
        unf_hit    = 1'b0;
        base       = clr ? '0 : count;
        dec_eff    = dec & ~clr;
        count_next = base;
        if (inc && !dec_eff) begin
            if (base == PEND_CNT_MAX) ovf_hit = 1'b1;
            else                      count_next = base + 1'b1;
        end else if (dec_eff && !inc) begin
            if (base == '0) unf_hit = 1'b1;
            else            count_next = base - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= count_next;
    end

    // Flags decoded straight from the register so they follow the last edge.
    always_comb begin
        full = (count == PEND_CNT_MAX);
        zero = (count == '0);
    end

endmodule

// File: rtl/wf_pending_tracker.sv
// Per-wavefront tracker of in-flight vector memory ops: id decode, per-slot
// counters, sticky overflow/underflow reporting and a registered count read.
module wf_pending_tracker
    import wf_pending_tracker_pkg::*;
#(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [WFID_W-1:0]     issue_wfid,
    input  logic                  retire_valid,
    input  logic [WFID_W-1:0]     retire_wfid,
    input  logic                  clear_valid,
    input  logic [WFID_W-1:0]     clear_wfid,
    input  logic                  err_clr,
    input  logic [WFID_W-1:0]     rd_wfid,
    output logic [PEND_CNT_W-1:0] rd_count,
    output logic [NUM_WF-1:0]     pending_full,
    output logic [NUM_WF-1:0]     pending_zero,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic [WFID_W-1:0]     err_wfid
);

    logic [NUM_WF-1:0]     issue_hit;
    logic [NUM_WF-1:0]     retire_hit;
    logic [NUM_WF-1:0]     clear_hit;
    logic [NUM_WF-1:0]     ovf_hit;
    logic [NUM_WF-1:0]     unf_hit;
    logic [PEND_CNT_W-1:0] slot_count [NUM_WF];
    logic                  ovf_any;
    logic                  unf_any;
    logic                  err_any;
    logic [WFID_W-1:0]     err_slot;
    logic                  err_captured;
    logic [PEND_CNT_W-1:0] rd_next;

    // One-hot id decoders; an out-of-range id selects no slot at all.
    always_comb begin
        issue_hit  = '0;
        retire_hit = '0;
        clear_hit  = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            issue_hit[i]  = issue_valid && wfid_in_range(32'(issue_wfid), NUM_WF)
                            && (issue_wfid == WFID_W'(i));
            retire_hit[i] = retire_valid && wfid_in_range(32'(retire_wfid), NUM_WF)
                            && (retire_wfid == WFID_W'(i));
            clear_hit[i]  = clear_valid && wfid_in_range(32'(clear_wfid), NUM_WF)
                            && (clear_wfid == WFID_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_WF; g++) begin : g_slot
        pending_count_slot u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clear_hit[g]),
            .inc     (issue_hit[g]),
            .dec     (retire_hit[g]),
            .count   (slot_count[g]),
            .full    (pending_full[g]),
            .zero    (pending_zero[g]),
            .ovf_hit (ovf_hit[g]),
            .unf_hit (unf_hit[g])
        );
    end

    // Error reduction and priority encode: an overflow slot beats an underflow
    // slot, lowest index first within each class.
    always_comb begin
        ovf_any  = |ovf_hit;
        unf_any  = |unf_hit;
        err_any  = ovf_any | unf_any;
        err_slot = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (unf_hit[i]) err_slot = WFID_W'(i);
        end
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (ovf_hit[i]) err_slot = WFID_W'(i);
        end
    end

    // Sticky error state; a same-cycle error beats err_clr as a fresh first error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            err_wfid      <= '0;
            err_captured  <= 1'b0;
        end else if (err_clr) begin
            overflow_err  <= ovf_any;
            underflow_err <= unf_any;
            err_captured  <= err_any;
            err_wfid      <= err_any ? err_slot : '0;
        end else begin
            overflow_err  <= overflow_err | ovf_any;
            underflow_err <= underflow_err | unf_any;
            if (err_any && !err_captured) begin
                err_captured <= 1'b1;
                err_wfid     <= err_slot;
            end
        end
    end

    // Read mux over the pre-update counts; unknown ids read as 0.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            if (rd_wfid == WFID_W'(i)) rd_next = slot_count[i];
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_count <= '0;
        else        rd_count <= rd_next;
    end

endmodule

// File: tb/tb_wf_pending_tracker.sv
// Bench for wf_pending_tracker: directed scenarios then random traffic,
// checked against a slot-by-slot reference model of the counting rules.
module tb_wf_pending_tracker;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    logic              clk;
    logic              rst_n;
    logic              issue_valid;
    logic [WFID_W-1:0] issue_wfid;
    logic              retire_valid;
    logic [WFID_W-1:0] retire_wfid;
    logic              clear_valid;
    logic [WFID_W-1:0] clear_wfid;
    logic              err_clr;
    logic [WFID_W-1:0] rd_wfid;
    logic [2:0]        rd_count;
    logic [NUM_WF-1:0] pending_full;
    logic [NUM_WF-1:0] pending_zero;
    logic              overflow_err;
    logic              underflow_err;
    logic [WFID_W-1:0] err_wfid;

    wf_pending_tracker #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_wfid    (issue_wfid),
        .retire_valid  (retire_valid),
        .retire_wfid   (retire_wfid),
        .clear_valid   (clear_valid),
        .clear_wfid    (clear_wfid),
        .err_clr       (err_clr),
        .rd_wfid       (rd_wfid),
        .rd_count      (rd_count),
        .pending_full  (pending_full),
        .pending_zero  (pending_zero),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .err_wfid      (err_wfid)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int unsigned m_cnt [NUM_WF];
    bit          m_ovf;
    bit          m_unf;
    bit          m_cap;
    int unsigned m_wfid;
    int unsigned m_rd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NUM_WF; w++) m_cnt[w] = 0;
        m_ovf = 0; m_unf = 0; m_cap = 0; m_wfid = 0; m_rd = 0;
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_edge();
        bit ovf, unf;
        int unsigned slot;
        ovf = 0; unf = 0;
        m_rd = (int'(rd_wfid) < NUM_WF) ? m_cnt[rd_wfid] : 0;
        for (int w = 0; w < NUM_WF; w++) begin
            bit i, d, c;
            i = issue_valid  && int'(issue_wfid)  == w;
            c = clear_valid  && int'(clear_wfid)  == w;
            d = retire_valid && int'(retire_wfid) == w && !c;
            if (c)           m_cnt[w] = i ? 1 : 0;
            else if (i && d) m_cnt[w] = m_cnt[w];
            else if (i)      begin if (m_cnt[w] == 7) ovf = 1; else m_cnt[w]++; end
            else if (d)      begin if (m_cnt[w] == 0) unf = 1; else m_cnt[w]--; end
        end
        slot = ovf ? int'(issue_wfid) : int'(retire_wfid);
        if (err_clr) begin
            m_ovf = ovf; m_unf = unf; m_cap = ovf | unf;
            m_wfid = (ovf | unf) ? slot : 0;
        end else begin
            m_ovf |= ovf; m_unf |= unf;
            if ((ovf | unf) && !m_cap) begin m_cap = 1; m_wfid = slot; end
        end
    endtask

    task automatic check_model(input string tag);
        logic [NUM_WF-1:0] ef, ez;
        for (int w = 0; w < NUM_WF; w++) begin
            ef[w] = (m_cnt[w] == 7);
            ez[w] = (m_cnt[w] == 0);
        end
        check({tag, ".rd_count"}, 64'(rd_count), 64'(m_rd));
        check({tag, ".full"}, 64'(pending_full), 64'(ef));
        check({tag, ".zero"}, 64'(pending_zero), 64'(ez));
        check({tag, ".ovf"}, 64'(overflow_err), 64'(m_ovf));
        check({tag, ".unf"}, 64'(underflow_err), 64'(m_unf));
        check({tag, ".err_wfid"}, 64'(err_wfid), 64'(m_wfid));
    endtask

    // driver: set inputs, take one edge, check shortly after it
    task automatic drive(input bit iv, input int iw, input bit rv, input int rw,
                         input bit cv, input int cw, input bit ec, input int rd);
        issue_valid = iv;  issue_wfid  = WFID_W'(iw);
        retire_valid = rv; retire_wfid = WFID_W'(rw);
        clear_valid = cv;  clear_wfid  = WFID_W'(cw);
        err_clr = ec;      rd_wfid     = WFID_W'(rd);
        model_edge();
        @(posedge clk);
        #1;
        check_model("step");
    endtask

    task automatic idle(input int rd);
        drive(0, 0, 0, 0, 0, 0, 0, rd);
    endtask

    initial begin
        rst_n = 1'b0;
        issue_valid = 0; issue_wfid = '0; retire_valid = 0; retire_wfid = '0;
        clear_valid = 0; clear_wfid = '0; err_clr = 0; rd_wfid = '0;
        model_reset();
        #12;
        check("reset.rd_count", 64'(rd_count), 64'd0);
        check("reset.full", 64'(pending_full), 64'd0);
        check("reset.zero", 64'(pending_zero), {24'd0, {NUM_WF{1'b1}}});
        check("reset.ovf", 64'(overflow_err), 64'd0);
        check("reset.unf", 64'(underflow_err), 64'd0);
        check("reset.err_wfid", 64'(err_wfid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // seven issues to wf 3 reach full without error
        drive(1, 3, 0, 0, 0, 0, 0, 3);
        check("wf3.zero_after_first", 64'(pending_zero[3]), 64'd0);
        for (int k = 0; k < 6; k++) drive(1, 3, 0, 0, 0, 0, 0, 3);
        check("wf3.full", 64'(pending_full[3]), 64'd1);
        check("wf3.no_ovf", 64'(overflow_err), 64'd0);
        idle(3);
        check("wf3.count7", 64'(rd_count), 64'd7);

        // 8th issue overflows; a later overflow elsewhere keeps err_wfid
        drive(1, 3, 0, 0, 0, 0, 0, 3);
        check("ovf.flag", 64'(overflow_err), 64'd1);
        check("ovf.err_wfid", 64'(err_wfid), 64'd3);
        for (int k = 0; k < 8; k++) drive(1, 5, 0, 0, 0, 0, 0, 3);
        check("ovf.keep_wfid", 64'(err_wfid), 64'd3);
        check("ovf.count_held", 64'(rd_count), 64'd7);

        // underflow on wf 9, then err_clr
        drive(0, 0, 1, 9, 0, 0, 0, 9);
        check("unf.flag", 64'(underflow_err), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 1, 9);
        check("clr.ovf", 64'(overflow_err), 64'd0);
        check("clr.unf", 64'(underflow_err), 64'd0);
        check("clr.err_wfid", 64'(err_wfid), 64'd0);
        check("unf.count0", 64'(rd_count), 64'd0);

        // same-slot combinations on wf 2
        for (int k = 0; k < 4; k++) drive(1, 2, 0, 0, 0, 0, 0, 2);
        drive(1, 2, 1, 2, 0, 0, 0, 2);
        idle(2);
        check("wf2.inc_dec", 64'(rd_count), 64'd4);
        drive(1, 2, 0, 0, 1, 2, 0, 2);
        idle(2);
        check("wf2.clear_issue", 64'(rd_count), 64'd1);
        drive(0, 0, 1, 2, 1, 2, 0, 2);
        idle(2);
        check("wf2.clear_retire", 64'(rd_count), 64'd0);
        check("wf2.no_unf", 64'(underflow_err), 64'd0);

        // out-of-range ids are ignored
        drive(1, 45, 1, 50, 1, 63, 0, 2);
        check("oob.no_ovf", 64'(overflow_err), 64'd0);

        // error and err_clr in the same cycle: error recorded fresh
        drive(0, 0, 1, 11, 0, 0, 0, 0);
        drive(0, 0, 1, 12, 0, 0, 1, 0);
        check("clr_vs_err.unf", 64'(underflow_err), 64'd1);
        check("clr_vs_err.wfid", 64'(err_wfid), 64'd12);

        // random traffic concentrated on a few slots to hit both saturations
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 2) != 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 29) == 0,
                  int'($urandom_range(0, NUM_WF - 1)));
            if ($urandom_range(0, 19) == 0)
                drive(1, int'($urandom_range(0, 63)), 1, int'($urandom_range(0, 63)),
                      0, 0, 0, int'($urandom_range(0, NUM_WF - 1)));
        end

        // async reset mid-burst with wf 0 at count 5
        drive(0, 0, 0, 0, 1, 0, 1, 0);
        for (int k = 0; k < 5; k++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        check("burst.count5", 64'(rd_count), 64'd5);
        issue_valid = 1; issue_wfid = '0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async.zero", 64'(pending_zero), {24'd0, {NUM_WF{1'b1}}});
        check("async.full", 64'(pending_full), 64'd0);
        check("async.rd_count", 64'(rd_count), 64'd0);
        check("async.ovf", 64'(overflow_err), 64'd0);
        issue_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(0);
        check("post_reset.rd_count", 64'(rd_count), 64'd0);
        check("post_reset.zero0", 64'(pending_zero[0]), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wf_pending_tracker.md
# wf_pending_tracker

Per-wavefront tracker of in-flight vector memory operations, sitting downstream of the 3-bit pending-count adder in the issue/LSU path. It holds one 3-bit count per wavefront slot. Counts increment on issue, decrement on retire, and reset on slot clear. It produces registered per-slot full/zero flags for issue stall and waitcnt logic, plus sticky error reporting for overflow and underflow.

## Interface
- NUM_WF, 40, number of wavefront slots tracked
- WFID_W, 6, width of wavefront id fields; must satisfy 2^WFID_W >= NUM_WF
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  one memory op issued this cycle
- issue_wfid  in  WFID_W  slot receiving the increment
- retire_valid  in  1  one memory op retired this cycle
- retire_wfid  in  WFID_W  slot receiving the decrement
- clear_valid  in  1  slot deallocated or reallocated; its count is forced to 0
- clear_wfid  in  WFID_W  slot being cleared
- err_clr  in  1  clears sticky error state
- rd_wfid  in  WFID_W  debug/waitcnt read address
- rd_count  out  3  count of rd_wfid, registered
- pending_full  out  NUM_WF  bit i = 1 when count[i] == 7
- pending_zero  out  NUM_WF  bit i = 1 when count[i] == 0
- overflow_err  out  1  sticky: increment attempted at count 7
- underflow_err  out  1  sticky: decrement attempted at count 0
- err_wfid  out  WFID_W  slot of the first error since reset or err_clr

## Operation
- State: NUM_WF x 3-bit count registers, two error flags, err_wfid, and a first-error-captured bit.
- Per-slot next count: base = 0 if the slot is cleared, else the current count. Then add inc − dec, where inc = issue hits the slot and dec = retire hits the slot and the slot is not cleared.
- Inc and dec on the same slot in the same cycle: count unchanged. No error, even at 0 or 7.
- Clear and issue on the same slot: result 1. Clear and retire on the same slot: result 0, retire dropped, no error.
- Overflow: inc only, count 7. Count holds at 7 and overflow_err is set.
- Underflow: dec only, count 0, not cleared. Count holds at 0 and underflow_err is set.
- err_wfid is captured only on the first error. Later errors set the flags but do not change err_wfid.
- If overflow and underflow occur on different slots in one cycle, both flags set and err_wfid takes the issue slot.
- err_clr zeroes both flags, err_wfid, and the captured bit. If an error occurs in the same cycle as err_clr, the error wins and is recorded as a fresh first error.
- Any wfid >= NUM_WF is ignored for that port: no update, no error.
- pending_full and pending_zero are decoded from the count registers, so they reflect counts as of the last edge.

## Timing
- Reset (rst_n low, async): all counts 0, pending_zero all 1, pending_full all 0, rd_count 0, both errors 0, err_wfid 0.
- An update at edge N is visible on pending_full/zero at N (+clk-to-q). An issue sampled at edge N sets full for use in cycle N+1.
- rd_count is registered: it shows the count of the rd_wfid sampled at edge N, as it stood before edge N's update, and is valid after edge N.
- Reset asserted mid-operation discards all counts immediately. The first post-reset edge sees all slots empty.
- No backpressure: every input is taken every cycle. Issue logic must gate issue_valid using pending_full.

## Structure
- Shared package holds: PEND_CNT_W = 3, PEND_CNT_MAX = 3'd7, and the wfid-valid compare helper.
- One natural sub-module, pending_count_slot. It holds one count register with the clear/inc/dec next-state logic and outputs full, zero, ovf_hit and unf_hit. It is generated NUM_WF times.
- The top level contains the id decoders, OR-reduction of the per-slot error hits, first-error capture with a priority encoder for err_wfid, and the rd_count mux register.

## Test plan
- Reset, then 7 issues to wf 3 → pending_zero[3]=0 after the first edge; count 7 and pending_full[3]=1 after the 7th; overflow_err=0.
- 8th issue to wf 3 → count stays 7, overflow_err=1, err_wfid=3. A later overflow on wf 5 leaves err_wfid=3.
- Retire to wf 9 at count 0 → underflow_err=1, count 0. err_clr → both flags 0, err_wfid 0.
- wf 2 at count 4 with simultaneous issue+retire → count 4. Clear+issue → 1. Clear+retire → 0, no error.
- Issue with wfid 45 (NUM_WF=40) → no count changes, no error.
- Drop rst_n mid-burst with wf 0 at count 5 → counts 0, pending_zero all 1 asynchronously; rd_count 0 after release.
